elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Collects hall/cabin call requests for floors F1..F3, holds them as pending calls and selects the next goal floor with SCAN (keep direction while calls lie ahead).
- Drives goal_floor/goal_valid into the motion logic; sequences door open time and stop/SOS/overweight interlocks.
- Sits between the button inputs and the floor/motion datapath.
- Floor encoding throughout: F1=2'd0, F2=2'd1, F3=2'd2; 2'd3 unused.

Parameters:
- DOOR_CYCLES, 8, clk cycles the door stays open per stop (>=2).
- NUM_FLOORS, 3, fixed at 3; other values unsupported.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- call_req  in  3  level call buttons, bit i = floor i; sampled every cycle.
- floor  in  2  current cabin floor from motion logic.
- moving  in  1  cabin in motion.
- weight_limit_exceeded  in  1  overweight interlock.
- sos_mode  in  1  emergency stop.
- goal_floor  out  2  target floor to motion logic.
- goal_valid  out  1  goal_floor is an active request to travel.
- door_open  out  1  door open command.
- pending  out  3  latched outstanding calls.
- dir_up  out  1  current sweep direction (1 = up).
- state  out  2  IDLE=0, MOVE=1, DOOR=2, HALT=3 (debug).

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pending=0, goal_floor=F1, goal_valid=0, door_open=0, dir_up=1, door counter=0.
- Pending: pending[i] set on any cycle with call_req[i]=1. It is cleared on the cycle DOOR is entered at floor i, and on every DOOR cycle while call_req[i]=1 at the current floor. A call at the stopped floor never stays latched.
- Arrival: arrived = (floor==goal_floor) && !moving.
- IDLE:
  - If sos_mode, go to HALT.
  - Else if pending[floor] or weight_limit_exceeded, go to DOOR.
  - Else if pending!=0, pick the target and go to MOVE with goal_valid=1 next cycle:
    - Nearest pending above floor if dir_up=1 and one exists.
    - Else nearest pending below, with dir_up<=0.
    - Else nearest above, with dir_up<=1.
  - Else stay in IDLE with goal_valid=0.
- MOVE:
  - goal_valid=1.
  - Retarget: if pending[F2] sets while floor=F1, goal=F3 and dir_up=1, or while floor=F3, goal=F1 and dir_up=0, then goal_floor<=F2 next cycle. No other retargeting.
  - On arrived, go to DOOR next cycle with goal_valid<=0.
  - weight_limit_exceeded is ignored in MOVE.
- DOOR:
  - door_open=1; counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - The counter reloads (door held) while call_req[floor]=1 or weight_limit_exceeded=1.
  - When counter==0 and no hold is active, go to IDLE with door_open<=0.
  - Door open time without holds is exactly DOOR_CYCLES cycles.
- HALT:
  - Entered from any state when sos_mode=1, with priority over all other transitions.
  - goal_valid=0, door_open=0, pending cleared, call_req ignored.
  - On sos_mode=0, go to IDLE; dir_up is kept.
- Simultaneous events:
  - sos_mode beats arrival.
  - Arrival plus a new call at the same floor: the call is absorbed in DOOR.
  - Calls on all floors at once: resolved by the SCAN order above.
- Outputs are registered; goal_floor is stable whenever goal_valid=1 except on a legal retarget.
- Reset asserted mid-MOVE or mid-DOOR returns all outputs immediately to reset values.

Test Plan:
- After reset at floor=F1, pulse call_req=3'b100 -> pending=100, next cycle state=MOVE, goal_floor=2, goal_valid=1, dir_up=1. Drive floor=2, moving=0 -> DOOR, door_open=1 for 8 cycles, pending=000, then IDLE.
- In MOVE toward F3 with floor=F1, pulse call_req[1] -> goal_floor becomes 1 next cycle. On arrival at F2, door opens 8 cycles. F3 stays pending and is served next with dir_up=1.
- At floor=F2 with dir_up=1, pending=101 -> goal F3 first, then F1 with dir_up=0. Door counter expiry between the two stops is observed.
- In DOOR, hold call_req[floor]=1 for 5 cycles, then weight_limit_exceeded=1 for 3 cycles -> door_open stays 1 throughout and closes exactly 8 cycles after the last hold cycle.
- Mid-MOVE assert sos_mode -> next cycle state=HALT, goal_valid=0, door_open=0, pending=000. Calls during HALT are not latched. Deassert -> IDLE.
- Assert rst_n=0 asynchronously in DOOR mid-count -> door_open=0, pending=0, goal_floor=0 without a clock edge.

Source files
------------

// File: rtl/elevator_call_scheduler_if.sv
// Button/motion-side signal bundle for the elevator call scheduler.
// The scheduler takes the master modport; the floor/motion side takes the slave modport.
interface elevator_call_scheduler_if;
  logic [2:0] call_req;
  logic [1:0] floor;
  logic       moving;
  logic       weight_limit_exceeded;
  logic       sos_mode;
  logic [1:0] goal_floor;
  logic       goal_valid;
  logic       door_open;
  logic [2:0] pending;
  logic       dir_up;
  logic [1:0] state;

  modport master (
    input  call_req, floor, moving, weight_limit_exceeded, sos_mode,
    output goal_floor, goal_valid, door_open, pending, dir_up, state
  );

  modport slave (
    output call_req, floor, moving, weight_limit_exceeded, sos_mode,
    input  goal_floor, goal_valid, door_open, pending, dir_up, state
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a three-floor elevator: latches calls, picks the next goal floor,
// times the door and applies SOS/overweight interlocks. All outputs are registered.
module elevator_call_scheduler #(
  parameter int unsigned DOOR_CYCLES = 8,
  parameter int unsigned NUM_FLOORS  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  elevator_call_scheduler_if.master        bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMove = 2'd1,
    StDoor = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam int unsigned CntW = $clog2(DOOR_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(DOOR_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      goal_q, goal_d;
  logic            valid_q, valid_d;
  logic            door_q, door_d;
  logic            dir_q, dir_d;
  logic [2:0]      pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0] floor_oh;
  logic       pend_here, req_here, arrived, hold;
  logic       above_vld, below_vld;
  logic [1:0] above_f, below_f;
  logic       retarget;

  always_comb begin
    floor_oh  = (bus.floor < 2'(NUM_FLOORS)) ? (3'b001 << bus.floor) : 3'b000;
    pend_here = |(pend_q & floor_oh);
    req_here  = |(bus.call_req & floor_oh);
    arrived   = (bus.floor == goal_q) && !bus.moving;
    hold      = req_here | bus.weight_limit_exceeded;
  end

  // Nearest latched call strictly above / below the cabin.
  always_comb begin
    above_vld = 1'b0;
    above_f   = 2'd0;
    below_vld = 1'b0;
    below_f   = 2'd0;
    case (bus.floor)
      2'd0: begin
        if (pend_q[1]) begin
          above_vld = 1'b1;
          above_f   = 2'd1;
        end else if (pend_q[2]) begin
          above_vld = 1'b1;
          above_f   = 2'd2;
        end
      end
      2'd1: begin
        if (pend_q[2]) begin
          above_vld = 1'b1;
          above_f   = 2'd2;
        end
        if (pend_q[0]) begin
          below_vld = 1'b1;
          below_f   = 2'd0;
        end
      end
      2'd2: begin
        if (pend_q[1]) begin
          below_vld = 1'b1;
          below_f   = 2'd1;
        end else if (pend_q[0]) begin
          below_vld = 1'b1;
          below_f   = 2'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    goal_d   = goal_q;
    valid_d  = valid_q;
    door_d   = door_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | bus.call_req;
    retarget = 1'b0;

    if (bus.sos_mode) begin
      state_d = StHalt;
      valid_d = 1'b0;
      door_d  = 1'b0;
      pend_d  = 3'b000;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend_here || bus.weight_limit_exceeded) begin
            state_d = StDoor;
            door_d  = 1'b1;
            cnt_d   = CntLoad;
          end else if (above_vld || below_vld) begin
            state_d = StMove;
            valid_d = 1'b1;
            if (dir_q && above_vld) begin
              goal_d = above_f;
            end else if (below_vld) begin
              goal_d = below_f;
              dir_d  = 1'b0;
            end else begin
              goal_d = above_f;
              dir_d  = 1'b1;
            end
          end
        end
        StMove: begin
          valid_d  = 1'b1;
          // Only an end-to-end sweep may be shortened to stop at the middle floor.
          retarget = pend_d[1] &&
                     (((bus.floor == 2'd0) && (goal_q == 2'd2) && dir_q) ||
                      ((bus.floor == 2'd2) && (goal_q == 2'd0) && !dir_q));
          if (arrived) begin
            state_d = StDoor;
            valid_d = 1'b0;
            door_d  = 1'b1;
            cnt_d   = CntLoad;
          end else if (retarget) begin
            goal_d = 2'd1;
          end
        end
        StDoor: begin
          if (hold) begin
            cnt_d = CntLoad;
          end else if (cnt_q == '0) begin
            state_d = StIdle;
            door_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StHalt: begin
          state_d = StIdle;
          pend_d  = 3'b000;
        end
      endcase

      // A call at the floor where the door is open is served, never latched.
      if (state_d == StDoor) begin
        pend_d = pend_d & ~floor_oh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      goal_q  <= 2'd0;
      valid_q <= 1'b0;
      door_q  <= 1'b0;
      dir_q   <= 1'b1;
      pend_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      goal_q  <= goal_d;
      valid_q <= valid_d;
      door_q  <= door_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.goal_floor = goal_q;
  assign bus.goal_valid = valid_q;
  assign bus.door_open  = door_q;
  assign bus.pending    = pend_q;
  assign bus.dir_up     = dir_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus random calls/interlocks, every cycle
// compared against a behavioural model; the bench also plays the motion logic.
module tb_elevator_call_scheduler;
  localparam int unsigned DoorCycles = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  elevator_call_scheduler_if bus ();

  elevator_call_scheduler #(
    .DOOR_CYCLES(DoorCycles),
    .NUM_FLOORS (3)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 travelling, 2 door open, 3 emergency halt.
  int         m_mode;
  logic [2:0] m_pend;
  int         m_goal;
  bit         m_valid, m_door, m_up;
  int         m_remain;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pend   = 3'b000;
    m_goal   = 0;
    m_valid  = 1'b0;
    m_door   = 1'b0;
    m_up     = 1'b1;
    m_remain = 0;
  endtask

  function automatic int nearest(input int fl, input logic [2:0] p, input bit up);
    for (int d = 1; d <= 2; d++) begin
      int f;
      f = up ? fl + d : fl - d;
      if (f >= 0 && f <= 2) begin
        if (p[f]) return f;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input logic [2:0] req, input int fl, input bit mv, input bit wle,
                            input bit sos);
    logic [2:0] old;
    logic [2:0] np;
    int         a, b;
    old = m_pend;
    np  = m_pend | req;
    if (sos) begin
      m_mode  = 3;
      m_valid = 1'b0;
      m_door  = 1'b0;
      m_pend  = 3'b000;
      return;
    end
    case (m_mode)
      0: begin
        if (old[fl] || wle) begin
          m_mode = 2; m_door = 1'b1; m_remain = DoorCycles; np[fl] = 1'b0;
        end else if (old != 3'b000) begin
          a = nearest(fl, old, 1'b1);
          b = nearest(fl, old, 1'b0);
          if (m_up && a >= 0) m_goal = a;
          else if (b >= 0) begin m_goal = b; m_up = 1'b0; end
          else begin m_goal = a; m_up = 1'b1; end
          m_mode  = 1;
          m_valid = 1'b1;
        end
      end
      1: begin
        if (fl == m_goal && !mv) begin
          m_mode = 2; m_valid = 1'b0; m_door = 1'b1; m_remain = DoorCycles; np[fl] = 1'b0;
        end else if (np[1] && ((fl == 0 && m_goal == 2 && m_up) ||
                               (fl == 2 && m_goal == 0 && !m_up))) begin
          m_goal = 1;
        end
      end
      2: begin
        if (req[fl]) np[fl] = 1'b0;
        if (req[fl] || wle) m_remain = DoorCycles;
        else m_remain--;
        if (m_remain == 0) begin m_mode = 0; m_door = 1'b0; end
      end
      default: begin
        m_mode = 0;
        np     = 3'b000;
      end
    endcase
    m_pend = np;
  endtask

  task automatic compare_model();
    check_val("state", 32'(bus.state), 32'(m_mode));
    check_val("pending", 32'(bus.pending), 32'(m_pend));
    check_val("goal_floor", 32'(bus.goal_floor), 32'(m_goal));
    check_val("goal_valid", 32'(bus.goal_valid), 32'(m_valid));
    check_val("door_open", 32'(bus.door_open), 32'(m_door));
    check_val("dir_up", 32'(bus.dir_up), 32'(m_up));
  endtask

  // Motion stand-in: starts moving toward the goal, steps a floor now and then, settles on arrival.
  task automatic env_update();
    if (m_valid && int'(bus.floor) != m_goal) begin
      if (!bus.moving) bus.moving = 1'b1;
      else if ($urandom_range(0, 2) == 0)
        bus.floor = (m_goal > int'(bus.floor)) ? bus.floor + 2'd1 : bus.floor - 2'd1;
    end else if (!m_valid || $urandom_range(0, 1) == 0) begin
      bus.moving = 1'b0;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step(bus.call_req, int'(bus.floor), bus.moving, bus.weight_limit_exceeded,
               bus.sos_mode);
    #1;
    compare_model();
    @(negedge clk);
    env_update();
  endtask

  task automatic wait_state(input string tag, input int st, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (int'(bus.state) == st) break;
      run_cycle();
    end
    check_val(tag, 32'(bus.state), 32'(st));
  endtask

  task automatic count_door(input string tag);
    int n;
    n = bus.door_open ? 1 : 0;
    for (int i = 0; i < 100 && bus.door_open; i++) begin
      run_cycle();
      if (bus.door_open) n++;
    end
    check_val(tag, 32'(n), 32'(DoorCycles));
  endtask

  initial begin
    int sos_left;
    bus.call_req              = 3'b000;
    bus.floor                 = 2'd0;
    bus.moving                = 1'b0;
    bus.weight_limit_exceeded = 1'b0;
    bus.sos_mode              = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", 32'(bus.state), 32'd0);
    check_val("rst_pending", 32'(bus.pending), 32'd0);
    check_val("rst_goal_valid", 32'(bus.goal_valid), 32'd0);
    check_val("rst_dir_up", 32'(bus.dir_up), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Call F3 from F1, then an F2 call while leaving F1 shortens the sweep.
    bus.call_req = 3'b100;
    run_cycle();
    bus.call_req = 3'b000;
    check_val("latch_f3", 32'(bus.pending), 32'd4);
    wait_state("to_move", 1, 4);
    check_val("goal_f3", 32'(bus.goal_floor), 32'd2);
    check_val("dir_up_f3", 32'(bus.dir_up), 32'd1);
    bus.call_req = 3'b010;
    run_cycle();
    bus.call_req = 3'b000;
    check_val("retarget_f2", 32'(bus.goal_floor), 32'd1);
    wait_state("door_f2", 2, 80);
    count_door("door_len_f2");
    wait_state("resume_move", 1, 4);
    check_val("resume_goal_f3", 32'(bus.goal_floor), 32'd2);
    check_val("resume_dir_up", 32'(bus.dir_up), 32'd1);
    wait_state("door_f3", 2, 80);
    count_door("door_len_f3");
    check_val("closed_idle", 32'(bus.state), 32'd0);

    // SOS mid-travel: halt, drop calls, resume idle keeping direction.
    bus.call_req = 3'b001;
    run_cycle();
    bus.call_req = 3'b000;
    wait_state("move_down", 1, 4);
    bus.sos_mode = 1'b1;
    run_cycle();
    check_val("sos_state", 32'(bus.state), 32'd3);
    check_val("sos_pending", 32'(bus.pending), 32'd0);
    bus.call_req = 3'b111;
    run_cycle();
    run_cycle();
    check_val("halt_ignores_calls", 32'(bus.pending), 32'd0);
    bus.call_req = 3'b000;
    bus.sos_mode = 1'b0;
    run_cycle();
    check_val("halt_exit", 32'(bus.state), 32'd0);
    check_val("halt_keeps_dir", 32'(bus.dir_up), 32'd0);

    // Door holds: cabin call for 5 cycles, overweight for 3, then exactly DoorCycles more.
    bus.call_req = 3'b001 << bus.floor;
    run_cycle();
    bus.call_req = 3'b000;
    wait_state("door_here", 2, 4);
    for (int i = 0; i < 5; i++) begin
      bus.call_req = 3'b001 << bus.floor;
      run_cycle();
      check_val("hold_call", 32'(bus.door_open), 32'd1);
    end
    bus.call_req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bus.weight_limit_exceeded = 1'b1;
      run_cycle();
      check_val("hold_weight", 32'(bus.door_open), 32'd1);
    end
    bus.weight_limit_exceeded = 1'b0;
    count_door("door_after_hold");

    // Asynchronous reset while the door counts down.
    bus.call_req = 3'b001 << bus.floor;
    run_cycle();
    bus.call_req = 3'b000;
    wait_state("door_pre_rst", 2, 4);
    run_cycle();
    run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_door", 32'(bus.door_open), 32'd0);
    check_val("arst_state", 32'(bus.state), 32'd0);
    check_val("arst_pending", 32'(bus.pending), 32'd0);
    check_val("arst_goal", 32'(bus.goal_floor), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random calls, overweight and SOS bursts against the model.
    sos_left = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] req;
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 11) == 0);
      bus.call_req              = req;
      bus.weight_limit_exceeded = ($urandom_range(0, 29) == 0);
      if (sos_left > 0) begin
        sos_left--;
        bus.sos_mode = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        sos_left     = int'($urandom_range(0, 4));
        bus.sos_mode = 1'b1;
      end else begin
        bus.sos_mode = 1'b0;
      end
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
